// File: rtl/pass_pkg.sv
// Shared types and defaults for the keypad password verifier.
package pass_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_LOCKOUT
  } state_e;

  localparam int DIGIT_W       = 4;
  localparam int PASS_LEN_DEF  = 4;
  localparam int MAX_TRIES_DEF = 3;

endpackage

// File: rtl/pass_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module pass_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pass_verifier.sv
// Keypad password verifier with try limit and lockout.
// Define PASS_TIMEOUT_EN to enable the inter-digit timeout.
module pass_verifier
  import pass_pkg::*;
#(
  parameter int PASS_LEN       = PASS_LEN_DEF,
  parameter int MAX_TRIES      = MAX_TRIES_DEF,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_data,
  output logic               key_ready,
  output logic [1:0]         rom_addr,
  input  logic [DIGIT_W-1:0] rom_data,
  output logic               pm,
  output logic               ptl,
  output logic               busy,
  output logic [1:0]         tries
);

  if (PASS_LEN < 1 || PASS_LEN > 4) begin : g_bad_len
    $error("pass_verifier: PASS_LEN must be 1..4");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 4) begin : g_bad_tries
    $error("pass_verifier: MAX_TRIES must be 1..4");
  end
  if (LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cyc
    $error("pass_verifier: bad cycle counts");
  end

  localparam logic [1:0] LAST  = 2'(PASS_LEN - 1);
  localparam logic [1:0] TLAST = 2'(MAX_TRIES - 1);
  localparam int         LW    = $clog2(LOCK_CYCLES + 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       mis_q, mis_d;
  logic [1:0] tries_q, tries_d;
  logic       pm_q, pm_d;
  logic       ptl_q, ptl_d;
  logic       accept;
  logic       lock_done;
  logic       tmo;

  assign key_ready = (state_q == S_COLLECT);
  assign accept    = key_valid && key_ready;

  pass_timer #(.W(LW)) u_lock (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q != S_LOCKOUT && state_d == S_LOCKOUT),
    .load_val_i (LW'(LOCK_CYCLES)),
    .en_i       (state_q == S_LOCKOUT),
    .done_o     (lock_done)
  );

`ifdef PASS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic tmo_arm;
  logic tmo_done;

  // Armed only once the first digit of an attempt is in.
  assign tmo_arm = (state_q == S_COLLECT) && (idx_q != '0) && !accept;
  assign tmo     = tmo_arm && tmo_done;

  pass_timer #(.W(TW)) u_tmo (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
    .en_i       (tmo_arm),
    .done_o     (tmo_done)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    tries_d = tries_q;
    pm_d    = 1'b0;
    ptl_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (!start) begin
          state_d = S_IDLE;
          idx_d   = '0;
          mis_d   = 1'b0;
        end else if (accept) begin
          if (key_data != rom_data) mis_d = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_CHECK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo) begin
          state_d = S_CHECK;
          idx_d   = '0;
          mis_d   = 1'b1;
        end
      end
      S_CHECK: begin
        idx_d = '0;
        mis_d = 1'b0;
        if (!mis_q) begin
          pm_d    = 1'b1;
          tries_d = '0;
          state_d = S_IDLE;
        end else if (tries_q == TLAST) begin
          ptl_d   = 1'b1;
          tries_d = '0;
          state_d = S_LOCKOUT;
        end else begin
          tries_d = tries_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_LOCKOUT: begin
        if (lock_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      tries_q <= '0;
      pm_q    <= 1'b0;
      ptl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      tries_q <= tries_d;
      pm_q    <= pm_d;
      ptl_q   <= ptl_d;
    end
  end

  assign rom_addr = idx_q;
  assign pm       = pm_q;
  assign ptl      = ptl_q;
  assign busy     = (state_q != S_IDLE);
  assign tries    = tries_q;

endmodule

// File: tb/tb_pass_verifier.sv
// Directed bench for pass_verifier; ROM holds passcode 3,7,1,9.
module tb_pass_verifier;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_ready;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic       pm;
  logic       ptl;
  logic       busy;
  logic [1:0] tries;

  logic [3:0] rom [4];
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  pass_verifier #(
    .PASS_LEN       (4),
    .MAX_TRIES      (3),
    .LOCK_CYCLES    (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pm        (pm),
    .ptl       (ptl),
    .busy      (busy),
    .tries     (tries)
  );

  // exp = {key_ready, pm, ptl, busy, tries[1:0]} after the edge
  typedef struct {
    logic       st;
    logic       kv;
    logic [3:0] kd;
    logic       rs;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic st, input logic kv, input int kd,
                   input logic rs, input logic rdy, input logic p,
                   input logic pt, input logic bz, input int tr);
    vec_t r;
    r.st  = st;
    r.kv  = kv;
    r.kd  = 4'(kd);
    r.rs  = rs;
    r.exp = {rdy, p, pt, bz, 2'(tr)};
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic digits(input int a, input int b, input int c, input int d,
                        input int tr, input logic bz_last);
    v(1, 1, a, 0, 1, 0, 0, 1, tr);
    v(1, 1, b, 0, 1, 0, 0, 1, tr);
    v(1, 1, c, 0, 1, 0, 0, 1, tr);
    v(1, 1, d, 0, 0, 0, 0, bz_last, tr);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom[0] = 4'd3;
    rom[1] = 4'd7;
    rom[2] = 4'd1;
    rom[3] = 4'd9;
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    cyc();
    cyc();
    chk("reset_state", {key_ready, pm, ptl, busy, tries, rom_addr},
        8'b0);
    reset = 1'b0;

    // correct entry
    v(1, 0, 0, 0, 1, 0, 0, 1, 0);
    digits(3, 7, 1, 9, 0, 1);
    v(1, 0, 0, 0, 0, 1, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 0, 1, 0);
    // one failure then success
    digits(3, 7, 1, 8, 0, 1);
    v(1, 0, 0, 0, 1, 0, 0, 1, 1);
    digits(3, 7, 1, 9, 1, 1);
    v(1, 0, 0, 0, 0, 1, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 0, 1, 0);
    // three failures, ptl, lockout with start held high
    for (int a = 0; a < 3; a++) begin
      digits(0, 0, 0, 0, a, 1);
      if (a < 2) v(1, 0, 0, 0, 1, 0, 0, 1, a + 1);
      else       v(1, 0, 0, 0, 0, 0, 1, 1, 0);
    end
    for (int i = 0; i < 16; i++) v(1, 0, 0, 0, 0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 1, 0, 0, 1, 0);
    // abort keeps tries; start drop during CHECK still yields pm
    digits(3, 7, 1, 8, 0, 1);
    v(1, 0, 0, 0, 1, 0, 0, 1, 1);
    v(1, 1, 3, 0, 1, 0, 0, 1, 1);
    v(1, 1, 7, 0, 1, 0, 0, 1, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 1);
    v(1, 0, 0, 0, 1, 0, 0, 1, 1);
    digits(3, 7, 1, 9, 1, 1);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset while in CHECK drops the verdict
    v(1, 0, 0, 0, 1, 0, 0, 1, 0);
    digits(3, 7, 1, 9, 0, 1);
    v(1, 0, 0, 1, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      start     = vq[i].st;
      key_valid = vq[i].kv;
      key_data  = vq[i].kd;
      reset     = vq[i].rs;
      cyc();
      chk($sformatf("vec%0d", i), {2'b00, key_ready, pm, ptl, busy, tries},
          {2'b00, vq[i].exp});
    end
    reset = 1'b0; start = 1'b0; key_valid = 1'b0;

    // rom_addr tracks idx, reset clears it mid-attempt
    start = 1'b1;
    cyc();
    key_valid = 1'b1; key_data = 4'd3;
    cyc();
    chk("addr_after_1", {6'b0, rom_addr}, 8'd1);
    key_data = 4'd7;
    cyc();
    chk("addr_after_2", {6'b0, rom_addr}, 8'd2);
    key_valid = 1'b0; reset = 1'b1;
    cyc();
    chk("addr_reset", {5'b0, rom_addr, busy}, 8'd0);
    reset = 1'b0; start = 1'b1;
    cyc();
    key_valid = 1'b1; key_data = 4'd3;
    cyc();
    key_valid = 1'b0;
`ifdef PASS_TIMEOUT_EN
    repeat (7) cyc();
    chk("tmo_before", {6'b0, key_ready, busy}, 8'b11);
    cyc();
    chk("tmo_check", {5'b0, key_ready, tries}, 8'b000);
    cyc();
    chk("tmo_retry", {4'b0, key_ready, busy, tries}, 8'b1101);
`else
    repeat (20) cyc();
    chk("no_tmo", {4'b0, key_ready, busy, tries}, 8'b1100);
    chk("no_tmo_addr", {6'b0, rom_addr}, 8'd1);
`endif
    start = 1'b0;
    cyc();
    chk("final_idle", {5'b0, busy, pm, ptl}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pass_verifier.md
# pass_verifier

Keypad-side password verifier for the home security controller. It answers the controller's password request: while the controller sits in its password state, it accepts 4-bit digits over a valid/ready handshake and compares them against the stored passcode read from the passcode ROM. It counts failed attempts and returns one of two single-cycle verdict pulses to the control FSM: `pm` (password match) or `ptl` (try limit reached). After `ptl` it enforces a lockout.

## Interface
- `PASS_LEN`, 4: digits per passcode; ROM addresses 0..PASS_LEN-1.
- `MAX_TRIES`, 3: failed attempts that trigger `ptl`.
- `LOCK_CYCLES`, 16: lockout length in clocks after `ptl`.
- `TIMEOUT_CYCLES`, 64: inter-digit timeout; used only with `PASS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level input; high while the controller is in its password state.
- `key_valid`  in  1  keypad digit present.
- `key_data`  in  4  keypad digit.
- `key_ready`  out  1  verifier accepts a digit this cycle.
- `rom_addr`  out  2  passcode ROM address (current digit index).
- `rom_data`  in  4  passcode digit; combinational ROM, valid in the same cycle.
- `pm`  out  1  one-cycle pulse: correct passcode entered.
- `ptl`  out  1  one-cycle pulse: MAX_TRIES failures reached.
- `busy`  out  1  high in every state except IDLE.
- `tries`  out  2  failed attempts so far.

## Operation
- States:
  - IDLE: `key_ready`=0. Moves to COLLECT when `start`=1.
  - COLLECT: `key_ready`=1. A digit is accepted when `key_valid` and `key_ready` are both high. On acceptance, `key_data` != `rom_data` sets the sticky `mismatch` flag, and `idx` increments. When the accepted digit is number PASS_LEN (idx = PASS_LEN-1), the FSM moves to CHECK.
  - CHECK: `key_ready`=0.
    - `mismatch`=0: register `pm`=1, clear `tries`, go to IDLE.
    - `mismatch`=1 and `tries`+1 = MAX_TRIES: register `ptl`=1, clear `tries`, go to LOCKOUT.
    - Otherwise: increment `tries`, clear `idx` and `mismatch`, go to COLLECT.
  - LOCKOUT: `key_ready`=0. Counts LOCK_CYCLES clocks, then goes to IDLE. `start` is ignored in this state.
- `rom_addr` = `idx` at all times.
- `start` falling while in COLLECT aborts the attempt: go to IDLE, clear `idx` and `mismatch`. The aborted attempt is not counted and `tries` is kept.
- `start` falling while in CHECK has no effect; the verdict is still issued.
- `tries` saturates at MAX_TRIES-1 between attempts. It never wraps.
- `idx` is 2 bits wide and never exceeds PASS_LEN-1. PASS_LEN > 4 is illegal; fail elaboration with a check.

## Timing
- Reset: state=IDLE, `idx`=0, `mismatch`=0, `tries`=0, `pm`=0, `ptl`=0, `key_ready`=0, `busy`=0, lockout and timeout counters = 0.
- `start` high at edge e → COLLECT from edge e; `key_ready` high in the cycle after e.
- Throughput: one digit per clock; back-to-back digits are allowed.
- Last digit accepted at edge k → CHECK during cycle k..k+1 → `pm` or `ptl` high for exactly the cycle after edge k+1. Latency is 2 clocks.
- LOCKOUT: `busy` is high for LOCK_CYCLES cycles after the `ptl` cycle; IDLE on the following edge.
- Reset asserted mid-operation overrides everything on the next edge. Any pending verdict is dropped and no pulse is emitted.

## Configuration
- `PASS_TIMEOUT_EN` defined:
  - In COLLECT with `idx` ≥ 1, TIMEOUT_CYCLES consecutive clocks with no accepted digit force CHECK with `mismatch`=1.
  - The timeout counter clears on every accepted digit.
- Undefined: no timeout logic. COLLECT waits indefinitely.

## Structure
- `pass_pkg` holds:
  - the state enum (IDLE, COLLECT, CHECK, LOCKOUT);
  - the digit width constant (4);
  - default PASS_LEN and MAX_TRIES.
- Sub-module `pass_timer`: a loadable down-counter with a `done` output. One instance serves LOCKOUT, and a second serves the timeout under the macro.

## Test plan
Bench ROM holds passcode 3,7,1,9 at addresses 0..3.
- Correct entry: `start`=1, digits 3,7,1,9 on consecutive cycles → `pm`=1 for one cycle 2 clocks after digit 9; `tries`=0; `ptl` never asserts.
- One failure, then success: 3,7,1,8 → `tries`=1, no pulse, `key_ready` returns 1; then 3,7,1,9 → `pm` pulse, `tries`=0.
- Three failures: 0,0,0,0 entered three times → `ptl` pulse after the third attempt; `key_ready`=0 for 16 cycles; IDLE afterwards.
- Abort: `start` drops after digits 3,7 → IDLE, `tries` unchanged. Re-raise `start` and enter 3,7,1,9 → `pm` pulse.
- Reset mid-attempt: assert `reset` one cycle after digit 9 → no `pm`; all outputs are at their reset values.
- With `PASS_TIMEOUT_EN`, TIMEOUT_CYCLES=8: enter digit 3, then stall 8 cycles → counted as a failure, `tries`=1.
